mem_port_arbiter: RTL and testbench

Two-channel arbiter that shares one single-port, fixed-latency memory between the two channels of an HLS-generated accelerator's master memory interface. It accepts the accelerator's per-channel `Mout_*` requests, serialises them onto the single memory port with round-robin priority, and returns per-channel `M_DataRdy` / `M_Rdata_ram`. It sits between `main` and the off-chip/testbench memory model, replacing per-channel direct memory access.

---
 rtl/mem_port_arbiter_pkg.sv | 40 ++++
 rtl/rr_arbiter2.sv | 33 +++
 rtl/mem_port_arbiter.sv | 144 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and helpers for the two-channel memory port arbiter.
// Request fields are sized to generous maxima and truncated at the port.
package mem_port_arbiter_pkg;

  localparam int unsigned MaxAddrW = 32;
  localparam int unsigned MaxDataW = 64;
  localparam int unsigned MaxSizeW = 8;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StRdWait,
    StAck
  } state_e;

  typedef enum logic {
    OpRead,
    OpWrite
  } op_e;

  typedef struct packed {
    op_e                 op;
    logic [MaxAddrW-1:0] addr;
    logic [MaxDataW-1:0] wdata;
    logic [MaxSizeW-1:0] size;
  } mem_req_t;

  // Bit-enable for a write of 'size' bits into a 'width'-bit word.
  function automatic logic [MaxDataW-1:0] wmask_f(input logic [MaxSizeW-1:0] size,
                                                  input int unsigned width);
    logic [MaxDataW-1:0] m;
    if (32'(size) >= width) begin
      m = '1;
    end else begin
      m = (MaxDataW'(1) << size) - MaxDataW'(1);
    end
    return m;
  endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-input round-robin arbiter; on a tie the channel not granted last time wins.
module rr_arbiter2 (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [1:0] req_i,
  input  logic       en_i,
  output logic       gnt_o,
  output logic       valid_o
);

  logic last_q, last_d;

  always_comb begin
    unique case (req_i)
      2'b01:   gnt_o = 1'b0;
      2'b10:   gnt_o = 1'b1;
      2'b11:   gnt_o = ~last_q;
      default: gnt_o = 1'b0;
    endcase
    valid_o = |req_i;
    last_d  = (en_i && valid_o) ? gnt_o : last_q;
  end

  // Reset to 1 so channel 0 wins the first tie.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      last_q <= 1'b1;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Serialises two accelerator memory channels onto one fixed-latency
// single-port memory, one access at a time, with round-robin priority.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned BITSIZE  = 8,
  parameter int unsigned ADDR_W   = 7,
  parameter int unsigned SIZE_W   = 4,
  parameter int unsigned READ_LAT = 2
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [1:0]           Mout_oe_ram,
  input  logic [1:0]           Mout_we_ram,
  input  logic [2*ADDR_W-1:0]  Mout_addr_ram,
  input  logic [2*BITSIZE-1:0] Mout_Wdata_ram,
  input  logic [2*SIZE_W-1:0]  Mout_data_ram_size,
  output logic [2*BITSIZE-1:0] M_Rdata_ram,
  output logic [1:0]           M_DataRdy,
  output logic                 mem_en,
  output logic                 mem_we,
  output logic [ADDR_W-1:0]    mem_addr,
  output logic [BITSIZE-1:0]   mem_wdata,
  output logic [BITSIZE-1:0]   mem_wmask,
  input  logic [BITSIZE-1:0]   mem_rdata,
  output logic                 err_both
);

  localparam int unsigned LatW = $clog2(READ_LAT + 1);

  state_e               state_q, state_d;
  mem_req_t             req_q, req_d, req_in;
  logic                 gnt_q, gnt_d;
  logic [LatW-1:0]      lat_cnt_q, lat_cnt_d;
  logic [1:0]           rdy_q, rdy_d;
  logic [2*BITSIZE-1:0] rdata_q, rdata_d;
  logic                 err_q, err_d;

  logic [1:0] req_vec;
  logic       arb_gnt, arb_valid, arb_en;

  assign req_vec = Mout_oe_ram | Mout_we_ram;

  rr_arbiter2 u_rr_arbiter2 (
    .clk_i   (clock),
    .rst_i   (reset),
    .req_i   (req_vec),
    .en_i    (arb_en),
    .gnt_o   (arb_gnt),
    .valid_o (arb_valid)
  );

  // Selected channel's request; oe wins when both oe and we are high.
  always_comb begin
    req_in       = '0;
    req_in.op    = Mout_oe_ram[arb_gnt] ? OpRead : OpWrite;
    req_in.addr  = MaxAddrW'(arb_gnt ? Mout_addr_ram[2*ADDR_W-1:ADDR_W]
                                     : Mout_addr_ram[ADDR_W-1:0]);
    req_in.wdata = MaxDataW'(arb_gnt ? Mout_Wdata_ram[2*BITSIZE-1:BITSIZE]
                                     : Mout_Wdata_ram[BITSIZE-1:0]);
    req_in.size  = MaxSizeW'(arb_gnt ? Mout_data_ram_size[2*SIZE_W-1:SIZE_W]
                                     : Mout_data_ram_size[SIZE_W-1:0]);
  end

  always_comb begin
    state_d   = state_q;
    req_d     = req_q;
    gnt_d     = gnt_q;
    lat_cnt_d = lat_cnt_q;
    rdy_d     = '0;
    rdata_d   = '0;
    err_d     = err_q | (|(Mout_oe_ram & Mout_we_ram));
    arb_en    = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (arb_valid) begin
          arb_en  = 1'b1;
          gnt_d   = arb_gnt;
          req_d   = req_in;
          state_d = StIssue;
        end
      end
      StIssue: begin
        if (req_q.op == OpWrite) begin
          rdy_d   = gnt_q ? 2'b10 : 2'b01;
          state_d = StAck;
        end else begin
          lat_cnt_d = LatW'(READ_LAT);
          state_d   = StRdWait;
        end
      end
      StRdWait: begin
        lat_cnt_d = lat_cnt_q - LatW'(1);
        if (lat_cnt_q == LatW'(1)) begin
          rdy_d   = gnt_q ? 2'b10 : 2'b01;
          rdata_d = gnt_q ? {mem_rdata, {BITSIZE{1'b0}}} : {{BITSIZE{1'b0}}, mem_rdata};
          state_d = StAck;
        end
      end
      StAck: begin
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= StIdle;
      req_q     <= '0;
      gnt_q     <= 1'b0;
      lat_cnt_q <= '0;
      rdy_q     <= '0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      req_q     <= req_d;
      gnt_q     <= gnt_d;
      lat_cnt_q <= lat_cnt_d;
      rdy_q     <= rdy_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
    end
  end

  // Memory command is a pure decode of the ISSUE state and the latched request.
  logic issue;
  assign issue     = (state_q == StIssue);
  assign mem_en    = issue;
  assign mem_we    = issue && (req_q.op == OpWrite);
  assign mem_addr  = issue ? ADDR_W'(req_q.addr) : '0;
  assign mem_wdata = issue ? BITSIZE'(req_q.wdata) : '0;
  assign mem_wmask = mem_we ? BITSIZE'(wmask_f(req_q.size, BITSIZE)) : '0;

  assign M_DataRdy   = rdy_q;
  assign M_Rdata_ram = rdata_q;
  assign err_both    = err_q;

  logic unused_req_bits;
  assign unused_req_bits = ^{req_q.addr, req_q.wdata, req_q.size};

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a small fixed-latency memory model.
module tb_mem_port_arbiter;

  localparam int unsigned ReadLat = 2;

  logic        clk;
  logic        rst;
  logic [1:0]  oe, we;
  logic [13:0] addr;
  logic [15:0] wdata;
  logic [7:0]  size;
  logic [15:0] rdata_o;
  logic [1:0]  rdy;
  logic        mem_en, mem_we, err;
  logic [6:0]  mem_addr;
  logic [7:0]  mem_wdata, mem_wmask, mem_rdata;

  int n_vec = 0;
  int n_mis = 0;

  mem_port_arbiter #(
    .BITSIZE  (8),
    .ADDR_W   (7),
    .SIZE_W   (4),
    .READ_LAT (ReadLat)
  ) dut (
    .clock              (clk),
    .reset              (rst),
    .Mout_oe_ram        (oe),
    .Mout_we_ram        (we),
    .Mout_addr_ram      (addr),
    .Mout_Wdata_ram     (wdata),
    .Mout_data_ram_size (size),
    .M_Rdata_ram        (rdata_o),
    .M_DataRdy          (rdy),
    .mem_en             (mem_en),
    .mem_we             (mem_we),
    .mem_addr           (mem_addr),
    .mem_wdata          (mem_wdata),
    .mem_wmask          (mem_wmask),
    .mem_rdata          (mem_rdata),
    .err_both           (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: masked writes, reads valid ReadLat cycles after mem_en.
  logic [7:0] mem  [128];
  logic [7:0] pipe [ReadLat];

  always @(posedge clk) begin
    if (mem_en && mem_we) mem[mem_addr] <= (mem[mem_addr] & ~mem_wmask) | (mem_wdata & mem_wmask);
    pipe[0] <= (mem_en && !mem_we) ? mem[mem_addr] : 8'hEE;
    for (int i = 1; i < int'(ReadLat); i++) pipe[i] <= pipe[i-1];
  end
  assign mem_rdata = pipe[ReadLat-1];

  task automatic check_eq(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_quiet(input string tag);
    check_eq({tag, "_rdy"}, {14'd0, rdy}, 16'h0);
    check_eq({tag, "_rdata"}, rdata_o, 16'h0);
    check_eq({tag, "_en"}, {15'd0, mem_en}, 16'h0);
  endtask

  initial begin
    for (int i = 0; i < 128; i++) mem[i] <= 8'h00;
    for (int i = 0; i < int'(ReadLat); i++) pipe[i] <= 8'hEE;
    mem[10] <= 8'h11;
    mem[20] <= 8'h22;
    mem[11] <= 8'h33;
    mem[6]  <= 8'hF0;
    rst = 1'b1; oe = '0; we = '0; addr = '0; wdata = '0; size = '0;
    tick(); tick();

    // Reset state
    check_quiet("rst");
    check_eq("rst_we", {15'd0, mem_we}, 16'h0);
    check_eq("rst_addr", {9'd0, mem_addr}, 16'h0);
    check_eq("rst_wdata", {8'd0, mem_wdata}, 16'h0);
    check_eq("rst_wmask", {8'd0, mem_wmask}, 16'h0);
    check_eq("rst_err", {15'd0, err}, 16'h0);
    rst = 1'b0;
    tick();
    check_quiet("idle0");

    // Ch0 write addr 5, data A5, size 8
    we = 2'b01; addr[6:0] = 7'd5; wdata[7:0] = 8'hA5; size[3:0] = 4'd8;
    tick();
    check_eq("w0_en", {15'd0, mem_en}, 16'h1);
    check_eq("w0_we", {15'd0, mem_we}, 16'h1);
    check_eq("w0_addr", {9'd0, mem_addr}, 16'd5);
    check_eq("w0_wdata", {8'd0, mem_wdata}, 16'hA5);
    check_eq("w0_wmask", {8'd0, mem_wmask}, 16'hFF);
    check_eq("w0_rdy_early", {14'd0, rdy}, 16'h0);
    tick();
    check_eq("w0_rdy", {14'd0, rdy}, 16'h1);
    check_eq("w0_en_off", {15'd0, mem_en}, 16'h0);
    we = 2'b00;
    tick();
    check_quiet("w0_idle");

    // Ch1 read addr 5 -> A5 in upper slice at t+4
    oe = 2'b10; addr[13:7] = 7'd5;
    tick();
    check_eq("r1_en", {15'd0, mem_en}, 16'h1);
    check_eq("r1_we", {15'd0, mem_we}, 16'h0);
    check_eq("r1_addr", {9'd0, mem_addr}, 16'd5);
    tick();
    check_eq("r1_rdy_t2", {14'd0, rdy}, 16'h0);
    tick();
    check_eq("r1_rdy_t3", {14'd0, rdy}, 16'h0);
    tick();
    check_eq("r1_rdy", {14'd0, rdy}, 16'h2);
    check_eq("r1_rdata", rdata_o, 16'hA500);
    oe = 2'b00;
    tick();
    check_quiet("r1_idle");

    // Tie from reset: ch0 first; ch0 re-requests so second tie goes to ch1
    rst = 1'b1;
    tick();
    rst = 1'b0;
    oe = 2'b11; addr[6:0] = 7'd10; addr[13:7] = 7'd20;
    tick();
    check_eq("tie_addr0", {9'd0, mem_addr}, 16'd10);
    tick(); tick(); tick();
    check_eq("tie_rdy0", {14'd0, rdy}, 16'h1);
    check_eq("tie_rdata0", rdata_o, 16'h0011);
    addr[6:0] = 7'd11;
    tick();
    check_quiet("tie_gap");
    tick();
    check_eq("tie_en1", {15'd0, mem_en}, 16'h1);
    check_eq("tie_addr1", {9'd0, mem_addr}, 16'd20);
    tick(); tick(); tick();
    check_eq("tie_rdy1", {14'd0, rdy}, 16'h2);
    check_eq("tie_rdata1", rdata_o, 16'h2200);
    oe = 2'b01;
    tick(); tick();
    check_eq("tie_addr2", {9'd0, mem_addr}, 16'd11);
    tick(); tick(); tick();
    check_eq("tie_rdy2", {14'd0, rdy}, 16'h1);
    check_eq("tie_rdata2", rdata_o, 16'h0033);
    oe = 2'b00;
    tick();

    // Partial-width write masks
    we = 2'b01; addr[6:0] = 7'd6; wdata[7:0] = 8'h3C; size[3:0] = 4'd4;
    tick();
    check_eq("sz4_wmask", {8'd0, mem_wmask}, 16'h0F);
    check_eq("sz4_wdata", {8'd0, mem_wdata}, 16'h3C);
    tick();
    check_eq("sz4_rdy", {14'd0, rdy}, 16'h1);
    addr[6:0] = 7'd7; size[3:0] = 4'd0;
    tick(); tick();
    check_eq("sz0_wmask", {8'd0, mem_wmask}, 16'h00);
    check_eq("sz0_we", {15'd0, mem_we}, 16'h1);
    tick();
    check_eq("sz0_rdy", {14'd0, rdy}, 16'h1);
    we = 2'b00;
    tick();
    check_eq("sz4_mem", {8'd0, mem[6]}, 16'hFC);

    // Ch1 oe and we together: sticky error, performed as read
    oe = 2'b10; we = 2'b10; addr[13:7] = 7'd5;
    tick();
    check_eq("both_err", {15'd0, err}, 16'h1);
    check_eq("both_we", {15'd0, mem_we}, 16'h0);
    tick(); tick(); tick();
    check_eq("both_rdy", {14'd0, rdy}, 16'h2);
    check_eq("both_rdata", rdata_o, 16'hA500);
    oe = 2'b00; we = 2'b00;
    tick(); tick();
    check_eq("both_sticky", {15'd0, err}, 16'h1);

    // Reset during RD_WAIT: read discarded, then normal service
    oe = 2'b01; addr[6:0] = 7'd5;
    tick(); tick();
    rst = 1'b1; oe = 2'b00;
    tick();
    check_quiet("rrst");
    check_eq("rrst_err", {15'd0, err}, 16'h0);
    check_eq("rrst_wmask", {8'd0, mem_wmask}, 16'h0);
    rst = 1'b0;
    tick();
    check_quiet("rrst_after1");
    tick();
    check_quiet("rrst_after2");
    we = 2'b10; addr[13:7] = 7'd9; wdata[15:8] = 8'h5A; size[7:4] = 4'd8;
    tick();
    check_eq("post_en", {15'd0, mem_en}, 16'h1);
    check_eq("post_addr", {9'd0, mem_addr}, 16'd9);
    check_eq("post_wmask", {8'd0, mem_wmask}, 16'hFF);
    tick();
    check_eq("post_rdy", {14'd0, rdy}, 16'h2);
    we = 2'b00;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
